// File: rtl/hazard_tracker.sv
// Pipeline-occupancy tracker for the 5-stage LEGv8 core: shadows EX/MEM/WB destination state,
// drives EX-stage forwarding selects, raises load-use stall / branch flush and counts both.
module hazard_tracker #(
    parameter int unsigned ZERO_REG = 31,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rd,
    input  logic [4:0]       id_rm,
    input  logic [4:0]       id_rn,
    input  logic             id_use_rm,
    input  logic             id_use_rn,
    input  logic             id_use_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             br_taken,
    output logic [4:0]       rd_alu,
    output logic [4:0]       rd_mem,
    output logic             FwdALU,
    output logic             FwdMem,
    output logic             stall,
    output logic             flush,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [4:0] ZR = 5'(ZERO_REG);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwrite;
        logic       memread;
    } slot_t;

    slot_t ex_q, mem_q, wb_q;
    slot_t ex_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             load_use;
    logic             src_hit;

    always_comb begin
        src_hit  = (id_use_rm && (id_rm == ex_q.rd))
                || (id_use_rn && (id_rn == ex_q.rd))
                || (id_use_rd && (id_rd == ex_q.rd));
        load_use = ex_q.valid && ex_q.memread && ex_q.regwrite
                && (ex_q.rd != ZR) && id_valid && src_hit;
    end

    // Branch kill dominates: a flushed consumer must not also stall.
    assign flush  = br_taken;
    assign stall  = load_use && !br_taken;

    assign FwdALU = mem_q.valid && mem_q.regwrite && !mem_q.memread && (mem_q.rd != ZR);
    assign FwdMem = wb_q.valid && wb_q.regwrite && (wb_q.rd != ZR);
    assign rd_alu = mem_q.rd;
    assign rd_mem = wb_q.rd;

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;

    always_comb begin
        ex_d = '0;
        if (!stall && !flush && id_valid) begin
            ex_d.valid    = 1'b1;
            ex_d.rd       = id_rd;
            ex_d.regwrite = id_regwrite;
            ex_d.memread  = id_memread;
        end
        stall_cnt_d = stall_cnt_q;
        if (stall && !(&stall_cnt_q))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        flush_cnt_d = flush_cnt_q;
        if (flush && !(&flush_cnt_q))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= ex_q;
            wb_q        <= mem_q;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_tracker.sv
// Directed-vector bench for hazard_tracker; a narrow-counter instance covers counter saturation.
module tb_hazard_tracker;

    logic        clk = 1'b0;
    logic        reset, reset2;
    logic        id_valid, id_use_rm, id_use_rn, id_use_rd, id_regwrite, id_memread;
    logic [4:0]  id_rd, id_rm, id_rn;
    logic        br_taken, br2;

    logic [4:0]  rd_alu, rd_mem;
    logic        FwdALU, FwdMem, stall, flush;
    logic [15:0] stall_count, flush_count;

    logic [4:0]  rd_alu2, rd_mem2;
    logic        FwdALU2, FwdMem2, stall2, flush2;
    logic [3:0]  stall_count2, flush_count2;

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    hazard_tracker #(.ZERO_REG(31), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rd(id_rd), .id_rm(id_rm),
        .id_rn(id_rn), .id_use_rm(id_use_rm), .id_use_rn(id_use_rn), .id_use_rd(id_use_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .br_taken(br_taken),
        .rd_alu(rd_alu), .rd_mem(rd_mem), .FwdALU(FwdALU), .FwdMem(FwdMem),
        .stall(stall), .flush(flush), .stall_count(stall_count), .flush_count(flush_count)
    );

    hazard_tracker #(.ZERO_REG(31), .CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset2), .id_valid(id_valid), .id_rd(id_rd), .id_rm(id_rm),
        .id_rn(id_rn), .id_use_rm(id_use_rm), .id_use_rn(id_use_rn), .id_use_rd(id_use_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .br_taken(br2),
        .rd_alu(rd_alu2), .rd_mem(rd_mem2), .FwdALU(FwdALU2), .FwdMem(FwdMem2),
        .stall(stall2), .flush(flush2), .stall_count(stall_count2), .flush_count(flush_count2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rd, input logic [4:0] rm,
                          input logic [4:0] rn, input logic urm, input logic urn,
                          input logic urd, input logic rw, input logic mr);
        id_valid    = v;
        id_rd       = rd;
        id_rm       = rm;
        id_rn       = rn;
        id_use_rm   = urm;
        id_use_rn   = urn;
        id_use_rd   = urd;
        id_regwrite = rw;
        id_memread  = mr;
    endtask

    task automatic nop();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1);
    end

    initial begin
        reset    = 1'b0;
        reset2   = 1'b0;
        br_taken = 1'b0;
        br2      = 1'b0;
        set_id(1'b1, 5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

        // Reset held for two edges with arbitrary ID inputs
        tick();
        tick();
        chk("rst_rd_alu", 32'(rd_alu), 0);
        chk("rst_rd_mem", 32'(rd_mem), 0);
        chk("rst_fwdalu", 32'(FwdALU), 0);
        chk("rst_fwdmem", 32'(FwdMem), 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_flush", 32'(flush), 0);
        chk("rst_scnt", 32'(stall_count), 0);
        chk("rst_fcnt", 32'(flush_count), 0);
        reset = 1'b1;
        nop();

        // ALU chain: ADD X3 then NOPs
        set_id(1'b1, 5'd3, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        nop();
        tick();
        chk("alu_rd_alu", 32'(rd_alu), 3);
        chk("alu_fwdalu", 32'(FwdALU), 1);
        chk("alu_fwdmem_early", 32'(FwdMem), 0);
        tick();
        chk("alu_rd_mem", 32'(rd_mem), 3);
        chk("alu_fwdmem", 32'(FwdMem), 1);
        chk("alu_fwdalu_off", 32'(FwdALU), 0);
        chk("alu_rd_alu_bubble", 32'(rd_alu), 0);
        chk("alu_scnt", 32'(stall_count), 0);

        // Load-use: LDUR X5 ; ADD X6,X5,X2
        set_id(1'b1, 5'd5, 5'd0, 5'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd6, 5'd5, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        #1;
        chk("lu_stall", 32'(stall), 1);
        chk("lu_flush", 32'(flush), 0);
        tick();
        chk("lu_scnt", 32'(stall_count), 1);
        chk("lu_stall_once", 32'(stall), 0);
        chk("lu_rd_alu", 32'(rd_alu), 5);
        chk("lu_fwdalu_load", 32'(FwdALU), 0);
        tick();
        chk("lu_rd_mem", 32'(rd_mem), 5);
        chk("lu_fwdmem", 32'(FwdMem), 1);
        nop();

        // Rd-as-source, invalid ID and unused-operand cases against LDUR X5 in ex
        set_id(1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd5, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        chk("urd_stall", 32'(stall), 1);
        set_id(1'b0, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        chk("idinv_stall", 32'(stall), 0);
        set_id(1'b1, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        chk("nouse_stall", 32'(stall), 0);
        nop();
        tick();
        chk("nouse_scnt", 32'(stall_count), 1);

        // XZR: LDUR X31 ; consumer reading X31
        set_id(1'b1, 5'd31, 5'd0, 5'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd4, 5'd0, 5'd31, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        #1;
        chk("xzr_stall", 32'(stall), 0);
        tick();
        nop();
        chk("xzr_rd_alu", 32'(rd_alu), 31);
        chk("xzr_fwdalu", 32'(FwdALU), 0);
        tick();
        chk("xzr_rd_mem", 32'(rd_mem), 31);
        chk("xzr_fwdmem", 32'(FwdMem), 0);

        // Branch priority over a live load-use hazard
        set_id(1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd8, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        br_taken = 1'b1;
        #1;
        chk("br_flush", 32'(flush), 1);
        chk("br_stall", 32'(stall), 0);
        tick();
        br_taken = 1'b0;
        #1;
        chk("br_flush_off", 32'(flush), 0);
        chk("br_fcnt", 32'(flush_count), 1);
        chk("br_scnt", 32'(stall_count), 1);
        chk("br_ex_bubble_stall", 32'(stall), 0);
        nop();
        tick();
        chk("br_rd_alu_bubble", 32'(rd_alu), 0);
        chk("br_rd_mem", 32'(rd_mem), 7);

        // Reset asserted during an active stall
        set_id(1'b1, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd10, 5'd0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        #1;
        chk("mr_stall_pre", 32'(stall), 1);
        reset = 1'b0;
        tick();
        chk("mr_stall", 32'(stall), 0);
        chk("mr_scnt", 32'(stall_count), 0);
        chk("mr_fcnt", 32'(flush_count), 0);
        chk("mr_rd_alu", 32'(rd_alu), 0);
        reset = 1'b1;
        nop();

        // Saturation on the 4-bit instance: LDUR X5,[X5] repeated stalls every other cycle
        set_id(1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        reset2 = 1'b1;
        repeat (20) tick();
        chk("sat_scnt_mid", 32'(stall_count2), 10);
        repeat (20) tick();
        chk("sat_scnt", 32'(stall_count2), 15);
        chk("sat_fcnt_zero", 32'(flush_count2), 0);
        br2 = 1'b1;
        repeat (20) tick();
        chk("sat_fcnt", 32'(flush_count2), 15);
        chk("sat_flush", 32'(flush2), 1);
        chk("sat_stall_masked", 32'(stall2), 0);
        chk("sat_scnt_hold", 32'(stall_count2), 15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_tracker.md
Name: hazard_tracker

Overview:
- Pipeline-occupancy tracker and hazard controller for the 5-stage LEGv8 core.
- Shadows the destination-register state of the EX, MEM and WB slots.
- Drives the rd_alu/rd_mem/FwdALU/FwdMem inputs of the EX-stage forwarding logic.
- Detects load-use hazards (stall) and taken-branch kills (flush), and keeps saturating hazard counters for debug.

Parameters:
- ZERO_REG, 31, register index that is never written and never forwarded or matched (XZR).
- CNT_W, 16, width of the stall and flush counters.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rd  in  5  ID destination register.
- id_rm  in  5  ID source register Rm.
- id_rn  in  5  ID source register Rn.
- id_use_rm  in  1  ID instruction reads Rm.
- id_use_rn  in  1  ID instruction reads Rn.
- id_use_rd  in  1  ID instruction reads Rd as a source (STUR data, CBZ operand).
- id_regwrite  in  1  ID instruction writes id_rd.
- id_memread  in  1  ID instruction is a load (LDUR).
- br_taken  in  1  branch resolved taken in EX this cycle.
- rd_alu  out  5  MEM-slot destination register.
- rd_mem  out  5  WB-slot destination register.
- FwdALU  out  1  MEM slot may forward its ALU result.
- FwdMem  out  1  WB slot may forward its writeback value.
- stall  out  1  hold PC and IF/ID; insert a bubble into EX.
- flush  out  1  kill IF/ID contents; insert a bubble into EX.
- stall_count  out  CNT_W  saturating count of stall cycles.
- flush_count  out  CNT_W  saturating count of flush cycles.

Behaviour:
- Slot state: three slots (ex, mem, wb), each holding {valid, rd, regwrite, memread}.
- Reset: when reset==0 at a clock edge, all slot valid bits, rd fields, counters and registered outputs go to 0. This takes priority over every other event, including mid-stall or mid-flush. With all slots invalid, stall, flush, FwdALU and FwdMem are therefore 0.
- Advance, every non-reset edge: wb <= mem; mem <= ex. The ex slot loads from the ID inputs, or loads a bubble (valid=0) when stall or flush is 1. The mem and wb slots always advance; stall never freezes them.
- rd_alu / rd_mem: registered fields mem.rd / wb.rd. Both are 0 after reset, and bubbles carry rd=0.
- FwdALU: combinational = mem.valid & mem.regwrite & ~mem.memread & (mem.rd != ZERO_REG). A load's data is not available from the ALU.
- FwdMem: combinational = wb.valid & wb.regwrite & (wb.rd != ZERO_REG).
- Load-use match: ex.valid & ex.memread & ex.regwrite & (ex.rd != ZERO_REG) & id_valid, ANDed with ((id_use_rm & id_rm==ex.rd) | (id_use_rn & id_rn==ex.rd) | (id_use_rd & id_rd==ex.rd)).
- stall: combinational = load-use match & ~br_taken.
- flush: combinational = br_taken. It has priority over stall; on a simultaneous hazard, stall=0 and flush=1.
- Stall duration: exactly one cycle per load-use hazard. The load moves to mem, so the match clears on the next cycle. The consumer then picks up the loaded value from the WB slot via FwdMem.
- Counters: stall_count increments on each cycle with stall=1; flush_count increments on each cycle with flush=1. Both saturate at all-ones with no wrap.
- Latency: slot outputs change one edge after the ID inputs are captured. stall and flush are zero-latency with respect to the current slot and ID state.
- X-safety: ID inputs are ignored for matching when id_valid=0. Such a cycle still loads the ex slot with valid=0.

Test Plan:
- Reset: hold reset=0 for 2 cycles with arbitrary inputs -> rd_alu=0, rd_mem=0, FwdALU=0, FwdMem=0, stall=0, flush=0, both counters 0.
- ALU chain: issue ADD X3 (regwrite), then NOPs -> after 2 edges rd_alu=3 and FwdALU=1; after 3 edges rd_mem=3, FwdMem=1, FwdALU=0.
- Load-use: issue LDUR X5, then ADD X6,X5,X2 (id_use_rm, id_rm=5) -> stall=1 for exactly one cycle and stall_count=1. On the following edge mem.rd=5 with FwdALU=0; one edge later FwdMem=1 with rd_mem=5.
- XZR: LDUR X31 followed by a consumer with id_rn=31 -> stall=0, and FwdMem stays 0 when that load reaches wb.
- Branch priority: load-use condition present with br_taken=1 -> flush=1, stall=0, ex slot becomes a bubble, flush_count=1, stall_count unchanged.
- Saturation and mid-op reset: force 70000 stall cycles with CNT_W=16 -> stall_count holds 65535. Then assert reset=0 during an active stall -> next edge stall=0 and both counters 0.
